// File: rtl/chebyshev_pkg.sv
// Shared widths and sequencer state encoding for the Chebyshev datapath and its sequencer.
package chebyshev_pkg;

  function automatic int unsigned out_w(input int unsigned wl, input int unsigned cl,
                                        input int unsigned widening);
    return 2 * wl + cl + widening;
  endfunction

  function automatic int unsigned ord_w(input int unsigned max_order);
    return (max_order < 1) ? 1 : $clog2(max_order + 1);
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/chebyshev_coeff_rf.sv
// Coefficient register file: async-cleared storage, range-checked write port, combinational read.
module chebyshev_coeff_rf
  import chebyshev_pkg::*;
#(
  parameter  int unsigned CL        = 4,
  parameter  int unsigned MAX_ORDER = 8,
  localparam int unsigned OW        = ord_w(MAX_ORDER)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          we,
  input  logic [OW-1:0] addr,
  input  logic [CL-1:0] data,
  input  logic [OW-1:0] rd_addr,
  output logic [CL-1:0] rd_data_c,
  output logic          range_err_c
);

  localparam int unsigned DEPTH   = MAX_ORDER + 1;
  localparam logic [OW-1:0] MAX_IDX = OW'(MAX_ORDER);

  logic [CL-1:0] mem [DEPTH];

  assign range_err_c = we && (addr > MAX_IDX);
  assign rd_data_c   = (rd_addr <= MAX_IDX) ? mem[rd_addr] : '0;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && !range_err_c) begin
      mem[addr] <= data;
    end
  end

endmodule

// File: rtl/chebyshev_sequencer.sv
// Streams x and coeff[N]..coeff[0] into the Chebyshev datapath and returns its result.
// Optional CHEB_SEQ_PERF_EN builds a wrapping 16-bit count of delivered results.
module chebyshev_sequencer
  import chebyshev_pkg::*;
#(
  parameter  int unsigned WL         = 4,
  parameter  int unsigned CL         = 4,
  parameter  int unsigned WIDENING   = 1,
  parameter  int unsigned MAX_ORDER  = 8,
  parameter  int unsigned DP_LATENCY = 2,
  localparam int unsigned OUT        = out_w(WL, CL, WIDENING),
  localparam int unsigned OW         = ord_w(MAX_ORDER)
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           cfg_we,
  input  logic [OW-1:0]  cfg_addr,
  input  logic [CL-1:0]  cfg_data,
  input  logic           cfg_order_we,
  input  logic [OW-1:0]  cfg_order,
  output logic           cfg_err,
  input  logic           x_valid,
  output logic           x_ready,
  input  logic [WL-1:0]  x_data,
  output logic [WL-1:0]  dp_data_in,
  output logic [CL-1:0]  dp_coeff_in,
  output logic           dp_first,
  input  logic [OUT-1:0] dp_data_out,
  output logic           y_valid,
  input  logic           y_ready,
  output logic [OUT-1:0] y_data,
  output logic           busy,
  output logic [15:0]    eval_count
);

  localparam int unsigned DRW     = (DP_LATENCY > 1) ? $clog2(DP_LATENCY) : 1;
  localparam logic [OW-1:0] MAX_IDX = OW'(MAX_ORDER);

  seq_state_t     state;
  logic [OW-1:0]  order_q;
  logic [OW-1:0]  idx_q;
  logic [DRW-1:0] drain_q;
  logic [OW-1:0]  rd_addr;
  logic [CL-1:0]  rd_data;
  logic           range_err;
  logic           idle;
  logic           x_fire;
  logic [OW-1:0]  order_clamp;

  assign idle        = (state == IDLE);
  assign x_ready     = idle && !cfg_we && !cfg_order_we;
  assign x_fire      = x_valid && x_ready;
  assign order_clamp = (cfg_order > MAX_IDX) ? MAX_IDX : cfg_order;

  // In IDLE the read port looks ahead at coeff[N]; during ISSUE it fetches the next lower index.
  always_comb begin
    rd_addr = order_q;
    if (!idle) rd_addr = idx_q - OW'(1);
  end

  chebyshev_coeff_rf #(
    .CL        (CL),
    .MAX_ORDER (MAX_ORDER)
  ) u_coeff_rf (
    .clock       (clock),
    .resetn      (resetn),
    .we          (cfg_we && idle),
    .addr        (cfg_addr),
    .data        (cfg_data),
    .rd_addr     (rd_addr),
    .rd_data_c   (rd_data),
    .range_err_c (range_err)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      order_q     <= '0;
      idx_q       <= '0;
      drain_q     <= '0;
      cfg_err     <= 1'b0;
      dp_data_in  <= '0;
      dp_coeff_in <= '0;
      dp_first    <= 1'b0;
      y_valid     <= 1'b0;
      y_data      <= '0;
      busy        <= 1'b0;
    end else begin
      // Config is frozen outside IDLE so an evaluation always sees handshake-time values.
      cfg_err <= ((cfg_we || cfg_order_we) && !idle) || range_err;
      if (cfg_order_we && idle) order_q <= order_clamp;

      case (state)
        IDLE: begin
          if (x_fire) begin
            state       <= ISSUE;
            busy        <= 1'b1;
            dp_data_in  <= x_data;
            dp_coeff_in <= rd_data;
            dp_first    <= 1'b1;
            idx_q       <= order_q;
          end
        end
        ISSUE: begin
          dp_first <= 1'b0;
          if (idx_q == '0) begin
            state       <= DRAIN;
            dp_coeff_in <= '0;
            drain_q     <= '0;
          end else begin
            idx_q       <= idx_q - OW'(1);
            dp_coeff_in <= rd_data;
          end
        end
        DRAIN: begin
          if (drain_q == DRW'(DP_LATENCY - 1)) begin
            state   <= HOLD;
            y_valid <= 1'b1;
            y_data  <= dp_data_out;
          end else begin
            drain_q <= drain_q + DRW'(1);
          end
        end
        HOLD: begin
          if (y_ready) begin
            state   <= IDLE;
            y_valid <= 1'b0;
            busy    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CHEB_SEQ_PERF_EN
  logic [15:0] eval_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      eval_q <= '0;
    end else if (y_valid && y_ready) begin
      eval_q <= eval_q + 16'd1;
    end
  end

  assign eval_count = eval_q;
`else
  assign eval_count = '0;
`endif

endmodule

// File: tb/tb_chebyshev_sequencer.sv
// Self-checking bench for chebyshev_sequencer with a Horner-style stand-in datapath.
module tb_chebyshev_sequencer;
  import chebyshev_pkg::*;

  localparam int unsigned WL         = 4;
  localparam int unsigned CL         = 4;
  localparam int unsigned WIDENING   = 1;
  localparam int unsigned MAX_ORDER  = 8;
  localparam int unsigned DP_LATENCY = 2;
  localparam int unsigned OUT        = out_w(WL, CL, WIDENING);
  localparam int unsigned OW         = ord_w(MAX_ORDER);

  logic           clock = 1'b0;
  logic           resetn;
  logic           cfg_we;
  logic [OW-1:0]  cfg_addr;
  logic [CL-1:0]  cfg_data;
  logic           cfg_order_we;
  logic [OW-1:0]  cfg_order;
  logic           cfg_err;
  logic           x_valid;
  logic           x_ready;
  logic [WL-1:0]  x_data;
  logic [WL-1:0]  dp_data_in;
  logic [CL-1:0]  dp_coeff_in;
  logic           dp_first;
  logic [OUT-1:0] dp_data_out;
  logic           y_valid;
  logic           y_ready;
  logic [OUT-1:0] y_data;
  logic           busy;
  logic [15:0]    eval_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hs_cnt   = 0;
  int exp_lat  = 0;
  int y_hs     = 0;

  logic signed [CL-1:0] sh_coef [MAX_ORDER+1];
  int                   sh_order;
  logic [OUT-1:0]       exp_q [$];

  chebyshev_sequencer #(
    .WL(WL), .CL(CL), .WIDENING(WIDENING), .MAX_ORDER(MAX_ORDER), .DP_LATENCY(DP_LATENCY)
  ) dut (
    .clock(clock), .resetn(resetn),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_order_we(cfg_order_we), .cfg_order(cfg_order), .cfg_err(cfg_err),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .dp_data_in(dp_data_in), .dp_coeff_in(dp_coeff_in), .dp_first(dp_first),
    .dp_data_out(dp_data_out),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
    .busy(busy), .eval_count(eval_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (!resetn) y_hs <= 0;
    else if (y_valid && y_ready) y_hs <= y_hs + 1;
  end

  // Stand-in datapath: Horner accumulator plus one output register, DP_LATENCY=2 overall.
  logic [OUT-1:0] acc = '0;
  logic [OUT-1:0] d1  = '0;
  always @(posedge clock) begin
    acc <= dp_first ? OUT'($signed(dp_coeff_in))
                    : OUT'($signed(acc) * $signed(dp_data_in) + $signed(dp_coeff_in));
    d1  <= acc;
  end
  assign dp_data_out = d1;

  function automatic logic [OUT-1:0] horner(input logic signed [WL-1:0] x, input int n);
    int r;
    r = int'(sh_coef[n]);
    for (int k = n - 1; k >= 0; k--) r = r * int'(x) + int'(sh_coef[k]);
    return OUT'(r);
  endfunction

  task automatic shadow_clear();
    for (int i = 0; i <= MAX_ORDER; i++) sh_coef[i] = '0;
    sh_order = 0;
  endtask

  task automatic cfg_coef(input logic [OW-1:0] a, input logic [CL-1:0] d, input logic want_err);
    @(negedge clock);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clock);
    cfg_we = 1'b0;
    n_checks++;
    if (cfg_err !== want_err) begin
      n_fail++;
      $display("FAIL cfg_err_pulse addr=%0d: got %b, want %b", a, cfg_err, want_err);
    end
    if (!want_err) sh_coef[a] = d;
    @(negedge clock);
    n_checks++;
    if (cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_err_width addr=%0d: got %b, want 0", a, cfg_err);
    end
  endtask

  task automatic cfg_ord(input logic [OW-1:0] n);
    @(negedge clock);
    cfg_order_we = 1'b1; cfg_order = n;
    @(negedge clock);
    cfg_order_we = 1'b0;
    n_checks++;
    if (cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_order_err n=%0d: got %b, want 0", n, cfg_err);
    end
    sh_order = (int'(n) > MAX_ORDER) ? MAX_ORDER : int'(n);
  endtask

  // Drives one sample; returns at the negedge right after the handshake edge.
  task automatic start_x(input logic [WL-1:0] x, output int waited);
    @(negedge clock);
    cfg_we = 1'b0; cfg_order_we = 1'b0;
    x_valid = 1'b1; x_data = x; waited = 0;
    #1;
    while (!x_ready && waited < 20) begin
      @(negedge clock); #1;
      waited++;
    end
    n_checks++;
    if (!x_ready) begin
      n_fail++;
      $display("FAIL x_accept: got x_ready=%b, want 1", x_ready);
    end
    exp_q.push_back(horner(x, sh_order));
    exp_lat = sh_order + 1 + DP_LATENCY;
    @(negedge clock);
    x_valid = 1'b0;
    hs_cnt = cyc;
  endtask

  task automatic finish_y(input int hold);
    int t;
    logic [OUT-1:0] e;
    t = 0;
    while (!y_valid && t < 60) begin
      @(negedge clock);
      t++;
    end
    n_checks++;
    if (!y_valid) begin
      n_fail++;
      $display("FAIL y_timeout: got y_valid=%b, want 1", y_valid);
    end
    n_checks++;
    if (cyc - hs_cnt !== exp_lat) begin
      n_fail++;
      $display("FAIL y_latency: got %0d, want %0d", cyc - hs_cnt, exp_lat);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    n_checks++;
    if (y_data !== e) begin
      n_fail++;
      $display("FAIL y_data: got %0h, want %0h", y_data, e);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      n_checks++;
      if (y_valid !== 1'b1 || y_data !== e || x_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_stable cyc%0d: got v=%b d=%0h xr=%b busy=%b, want 1 %0h 0 1",
                 i, y_valid, y_data, x_ready, busy, e);
      end
    end
    y_ready = 1'b1;
    @(negedge clock);
    y_ready = 1'b0;
    n_checks++;
    if (y_valid !== 1'b0 || x_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL y_release: got v=%b xr=%b busy=%b, want 0 1 0", y_valid, x_ready, busy);
    end
  endtask

  // Checks the issue stream; entered in ISSUE cycle 0, leaves in DRAIN cycle 0.
  task automatic check_issue(input logic [WL-1:0] x);
    for (int k = 0; k <= sh_order; k++) begin
      n_checks++;
      if (dp_coeff_in !== sh_coef[sh_order-k] || dp_first !== (k == 0) || dp_data_in !== x) begin
        n_fail++;
        $display("FAIL issue k=%0d: got c=%h f=%b x=%h, want c=%h f=%b x=%h", k,
                 dp_coeff_in, dp_first, dp_data_in, sh_coef[sh_order-k], k == 0, x);
      end
      @(negedge clock);
    end
    n_checks++;
    if (dp_coeff_in !== '0 || dp_first !== 1'b0 || dp_data_in !== x || y_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: got c=%h f=%b x=%h v=%b, want 0 0 %h 0",
               dp_coeff_in, dp_first, dp_data_in, y_valid, x);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++;
    if (y_valid !== 1'b0 || busy !== 1'b0 || dp_coeff_in !== '0 || dp_first !== 1'b0 ||
        dp_data_in !== '0 || y_data !== '0 || cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: got v=%b busy=%b c=%h f=%b x=%h y=%h err=%b, want all 0",
               y_valid, busy, dp_coeff_in, dp_first, dp_data_in, y_data, cfg_err);
    end
    resetn = 1'b1;
    #1;
    n_checks++;
    if (x_ready !== 1'b1 || y_valid !== 1'b0 || busy !== 1'b0 || eval_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_release: got xr=%b v=%b busy=%b cnt=%0d, want 1 0 0 0",
               x_ready, y_valid, busy, eval_count);
    end
    shadow_clear();
  endtask

  task automatic test_basic();
    int w;
    cfg_coef(4'd0, 4'b0010, 1'b0);
    cfg_coef(4'd1, 4'b0010, 1'b0);
    cfg_ord(4'd1);
    start_x(4'b0100, w);
    check_issue(4'b0100);
    finish_y(0);
  endtask

  task automatic test_order0();
    int w;
    cfg_coef(4'd0, 4'b0011, 1'b0);
    cfg_ord(4'd0);
    start_x(4'b0110, w);
    check_issue(4'b0110);
    finish_y(0);
  endtask

  task automatic test_hold();
    int w;
    cfg_coef(4'd2, 4'b0101, 1'b0);
    cfg_coef(4'd1, 4'b1101, 1'b0);
    cfg_coef(4'd0, 4'b0001, 1'b0);
    cfg_ord(4'd2);
    start_x(4'b1110, w);
    check_issue(4'b1110);
    finish_y(5);
  endtask

  task automatic test_cfg_err();
    int w;
    cfg_ord(4'd3);
    cfg_coef(4'd3, 4'b0111, 1'b0);
    start_x(4'b0011, w);
    cfg_coef(4'd0, 4'b0111, 1'b1);
    finish_y(0);
    cfg_coef(4'd9, 4'b0110, 1'b1);
    start_x(4'b0011, w);
    finish_y(0);
  endtask

  task automatic test_collision();
    int w;
    cfg_ord(4'd0);
    @(negedge clock);
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 4'b0101;
    x_valid = 1'b1; x_data = 4'b0010;
    #1;
    n_checks++;
    if (x_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_x_ready: got %b, want 0", x_ready);
    end
    sh_coef[0] = 4'b0101;
    start_x(4'b0010, w);
    n_checks++;
    if (w !== 0) begin
      n_fail++;
      $display("FAIL collide_accept_delay: got %0d, want 0", w);
    end
    finish_y(0);
  endtask

  task automatic test_max_order();
    int w;
    cfg_ord(4'd12);
    for (int i = 0; i <= MAX_ORDER; i++)
      cfg_coef(OW'(i), CL'(($urandom_range(0, 15))), 1'b0);
    start_x(4'b0001, w);
    check_issue(4'b0001);
    finish_y(1);
    start_x(4'b1111, w);
    finish_y(0);
  endtask

  task automatic test_reset_mid();
    int w;
    logic seen;
    cfg_ord(4'd3);
    start_x(4'b0101, w);
    @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || y_valid !== 1'b0 || dp_coeff_in !== '0 || dp_first !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got busy=%b v=%b c=%h f=%b, want 0 0 0 0",
               busy, y_valid, dp_coeff_in, dp_first);
    end
    exp_q.delete();
    shadow_clear();
    @(negedge clock);
    resetn = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clock);
      if (y_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_no_result: got y_valid seen=%b, want 0", seen);
    end
    start_x(4'b0111, w);
    finish_y(0);
  endtask

  task automatic test_back_to_back();
    int w;
    cfg_coef(4'd1, 4'b1001, 1'b0);
    cfg_coef(4'd0, 4'b0100, 1'b0);
    cfg_ord(4'd1);
    for (int i = 0; i < 3; i++) begin
      start_x(WL'($urandom_range(0, 15)), w);
      finish_y(i);
    end
  endtask

  initial begin
    resetn = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    cfg_order_we = 1'b0; cfg_order = '0; x_valid = 1'b0; x_data = '0; y_ready = 1'b0;
    shadow_clear();
    test_reset();
    test_basic();
    test_order0();
    test_hold();
    test_cfg_err();
    test_collision();
    test_max_order();
    test_back_to_back();
    test_reset_mid();
    test_back_to_back();
    @(negedge clock);
    n_checks++;
`ifdef CHEB_SEQ_PERF_EN
    if (eval_count !== 16'(y_hs)) begin
      n_fail++;
      $display("FAIL eval_count: got %0d, want %0d", eval_count, y_hs);
    end
`else
    if (eval_count !== 16'd0) begin
      n_fail++;
      $display("FAIL eval_count: got %0d, want 0", eval_count);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
